// File: rtl/psmac_pkg.sv
// Shared definitions for the digit-serial MAC sequencer.
//   state_t : sequencer FSM state (IDLE, RUN, DONE)
//   DIGIT_W : width of one operand digit
//   PROD_W  : width of the two's complement digit product
package psmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W = 2;
  localparam int unsigned PROD_W  = 5;

endpackage

// File: rtl/psmac_align.sv
// Aligns one digit product to its weight inside the accumulator.
//   p     : two's complement digit product
//   shift : digit position i+j; the product is scaled by 4**shift
//   term  : p sign-extended to ACC_W and shifted left by 2*shift
module psmac_align
  import psmac_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SUM_W = 3
) (
  input  logic [PROD_W-1:0] p,
  input  logic [SUM_W-1:0]  shift,
  output logic [ACC_W-1:0]  term
);

  logic [ACC_W-1:0] ext;

  always_comb begin
    ext  = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    // Each digit position is worth two bits.
    term = ext << {shift, 1'b0};
  end

endmodule

// File: rtl/psmac_digit_seq.sv
// Digit-serial multiply-accumulate sequencer. Walks all N*N digit pairs of
// the latched operands through an external 2-bit digit multiplier and sums
// the aligned partial products into acc.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_ready   : operand handshake (a, b, signedness, acc_clr)
//   md, mr, sx, sy       : digits and sign-extension enables to the multiplier
//   p                    : digit product returned by the multiplier
//   out_valid, out_ready : result handshake; acc is final while out_valid
//   acc                  : running accumulator
module psmac_digit_seq
  import psmac_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned OP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              a_signed,
  input  logic              b_signed,
  input  logic              acc_clr,
  output logic [1:0]        md,
  output logic [1:0]        mr,
  output logic              sx,
  output logic              sy,
  input  logic [PROD_W-1:0] p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc
);

  localparam int unsigned N     = OP_W / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic             as_q;
  logic             bs_q;
  logic [CNT_W-1:0] i;
  logic [CNT_W-1:0] j;
  logic [CNT_W:0]   digit_sum;
  logic [ACC_W-1:0] term;
  logic             run;

  always_comb begin
    run       = (state == RUN);
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    digit_sum = {1'b0, i} + {1'b0, j};
    md        = '0;
    mr        = '0;
    sx        = 1'b0;
    sy        = 1'b0;
    if (run) begin
      md = a_q[{i, 1'b0} +: DIGIT_W];
      mr = b_q[{j, 1'b0} +: DIGIT_W];
      // Only the top digit of a signed operand carries the sign.
      sx = as_q & (i == LAST);
      sy = bs_q & (j == LAST);
    end
  end

  psmac_align #(
    .ACC_W (ACC_W),
    .SUM_W (CNT_W + 1)
  ) u_align (
    .p     (p),
    .shift (digit_sum),
    .term  (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      as_q  <= 1'b0;
      bs_q  <= 1'b0;
      i     <= '0;
      j     <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            as_q  <= a_signed;
            bs_q  <= b_signed;
            i     <= '0;
            j     <= '0;
            if (acc_clr) acc <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc + term;
          if (j == LAST) begin
            j <= '0;
            i <= i + 1'b1;
            if (i == LAST) begin
              i     <= '0;
              state <= DONE;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psmac_digit_seq.sv
module tb_psmac_digit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        a_signed = 1'b0;
  logic        b_signed = 1'b0;
  logic        acc_clr = 1'b0;
  logic [1:0]  md;
  logic [1:0]  mr;
  logic        sx;
  logic        sy;
  logic [4:0]  p;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] acc;

  psmac_digit_seq #(
    .ACC_W (24),
    .OP_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .acc_clr   (acc_clr),
    .md        (md),
    .mr        (mr),
    .sx        (sx),
    .sy        (sy),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  // Golden digit multiplier: 3-bit two's complement factors.
  logic signed [2:0] fx;
  logic signed [2:0] fy;
  logic signed [5:0] prod;
  always_comb begin
    fx   = {sx & md[1], md};
    fy   = {sy & mr[1], mr};
    prod = fx * fy;
  end
  assign p = prod[4:0];

  int passes = 0;
  int total  = 0;
  logic [23:0] model = '0;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        vas;
    logic        vbs;
    logic        vclr;
    logic [23:0] vexp;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: full-precision product of the interpreted operands, mod 2^24.
  task automatic model_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tas, input logic tbs, input logic tclr);
    longint sa, sb, tmp;
    sa = tas ? longint'($signed(ta)) : longint'(ta);
    sb = tbs ? longint'($signed(tb)) : longint'(tb);
    if (tclr) model = '0;
    tmp = longint'(model) + sa * sb;
    model = tmp[23:0];
  endtask

  // Returns at the negedge right after the accept edge.
  task automatic accept(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tas, input logic tbs, input logic tclr);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("accept_wait", 0, 1);
    a = ta; b = tb; a_signed = tas; b_signed = tbs; acc_clr = tclr;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_clr = 1'b0;
    model_op(ta, tb, tas, tbs, tclr);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model = '0;
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb;
    logic ras, rbs, rclr;
    logic [7:0] ba, bb;

    vecs[0] = '{8'd255, 8'd255, 1'b0, 1'b0, 1'b1, 24'd65025};
    vecs[1] = '{8'h80,  8'h7F,  1'b1, 1'b1, 1'b1, 24'hFFC080};
    vecs[2] = '{8'hFF,  8'hFF,  1'b1, 1'b0, 1'b1, 24'hFFFF01};
    vecs[3] = '{8'd3,   8'd4,   1'b0, 1'b0, 1'b0, 24'hFFFF0D};

    #2 rst_n = 1'b0;
    #1;
    check("reset_acc", acc, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_digits", {md, mr, sx, sy}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);

    // Directed table.
    for (int k = 0; k < 4; k++) begin
      accept(vecs[k].va, vecs[k].vb, vecs[k].vas, vecs[k].vbs, vecs[k].vclr);
      wait_done(lat);
      check($sformatf("vec%0d_latency", k), lat, 16);
      check($sformatf("vec%0d_acc", k), acc, vecs[k].vexp);
      release_res();
      check($sformatf("vec%0d_idle", k), {in_ready, out_valid}, 2'b10);
    end

    // Digit walk, ignored in_valid during RUN, then backpressure in DONE.
    ba = 8'hB6; bb = 8'h5D;
    accept(ba, bb, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) begin
      int di, dj;
      di = k / 4;
      dj = k % 4;
      check($sformatf("md_step%0d", k), md, (int'(ba) >> (2 * di)) & 3);
      check($sformatf("mr_step%0d", k), mr, (int'(bb) >> (2 * dj)) & 3);
      check($sformatf("sx_step%0d", k), sx, (di == 3) ? 1 : 0);
      check($sformatf("sy_step%0d", k), sy, (dj == 3) ? 1 : 0);
      check($sformatf("run_in_ready%0d", k), in_ready, 0);
      a = 8'h11; b = 8'h22; acc_clr = 1'b1;
      in_valid = (k % 2 == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    acc_clr = 1'b0;
    check("bp_out_valid", out_valid, 1);
    check("bp_acc", acc, model);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp_hold_acc%0d", k), acc, model);
      check($sformatf("bp_hold_flags%0d", k), {out_valid, in_ready}, 2'b10);
    end
    in_valid = 1'b0;
    release_res();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_acc", acc, model);

    // Reset in the middle of RUN.
    accept(8'd200, 8'd100, 1'b0, 1'b0, 1'b1);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_acc", acc, 0);
    check("midrun_reset_digits", {md, mr, sx, sy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model = '0;
    @(negedge clk);
    check("after_reset_in_ready", in_ready, 1);
    check("after_reset_acc", acc, 0);
    accept(8'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    check("after_reset_latency", lat, 16);
    check("after_reset_acc_6", acc, 6);
    release_res();

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ras = 1'($urandom);
      rbs = 1'($urandom);
      rclr = ($urandom_range(0, 3) == 0);
      accept(ra, rb, ras, rbs, rclr);
      wait_done(lat);
      check($sformatf("rand%0d_latency", k), lat, 16);
      check($sformatf("rand%0d_acc", k), acc, model);
      release_res();
    end

    // Wrap-around: 1024 x (-128 * -128) from zero is 2^24.
    pulse_reset();
    for (int k = 1; k <= 1024; k++) begin
      accept(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
      wait_done(lat);
      if (k == 1) check("wrap_first_acc", acc, 16384);
      if (k == 512) check("wrap_half_acc", acc, 24'h800000);
      if (k == 1024) begin
        check("wrap_final_latency", lat, 16);
        check("wrap_final_acc", acc, 0);
      end
      release_res();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

// File: doc/psmac_digit_seq.md
PSMAC_DIGIT_SEQ -- requirements
Module: psmac_digit_seq

Interface
REQ-001 Parameter ACC_W, default 24: accumulator width in bits, signed two's complement, >= 18.
REQ-002 Parameter OP_W, default 8: operand width in bits, even, split into OP_W/2 2-bit digits.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand pair is offered.
REQ-006 in_ready  output  1  block accepts a pair this cycle.
REQ-007 a, b  input  OP_W each  multiplicand and multiplier.
REQ-008 a_signed, b_signed  input  1 each  operand is signed (1) or unsigned (0).
REQ-009 acc_clr  input  1  accumulation starts from zero instead of the current acc.
REQ-010 md, mr  output  2 each  current multiplicand and multiplier digits, driven to the external digit multiplier.
REQ-011 sx, sy  output  1 each  sign-extension enables for md and mr.
REQ-012 p  input  5  digit product returned combinationally by the digit multiplier, two's complement.
REQ-013 out_valid  input/output: output  1  acc holds a completed MAC result.
REQ-014 out_ready  input  1  consumer takes the result.
REQ-015 acc  output  ACC_W  accumulator value.

Function
REQ-016 Digit product contract: p equals {sx&md[1],md} times {sy&mr[1],mr}, with both factors read as 3-bit two's complement values.
REQ-017 FSM states:
- IDLE: in_ready = 1.
- RUN: exactly N*N cycles, with N = OP_W/2.
- DONE: out_valid = 1.
REQ-018 IDLE -> RUN on in_valid & in_ready. On that edge the block:
- latches a, b, a_signed and b_signed;
- loads acc with 0 if acc_clr, otherwise keeps acc;
- clears the step counters i and j.
REQ-019 In RUN, step (i,j) drives md = a[2i+1:2i] and mr = b[2j+1:2j].
REQ-020 In RUN, sx = a_signed & (i==N-1) and sy = b_signed & (j==N-1).
REQ-021 Outside RUN, md, mr, sx and sy are all 0.
REQ-022 Each RUN edge adds sign-extended p, shifted left by 2*(i+j), to acc; arithmetic wraps modulo 2^ACC_W.
REQ-023 Step order: j is the inner index, i the outer, from (0,0) to (N-1,N-1).
REQ-024 The edge that applies step (N-1,N-1) moves the FSM to DONE. For OP_W = 8, out_valid rises 16 cycles after the accept edge.
REQ-025 DONE -> IDLE on out_ready. out_valid and acc remain stable while out_ready = 0.
REQ-026 in_ready is 0 in RUN and DONE. in_valid is ignored there, with no buffering.
REQ-027 acc is the latest value at all times; its value is final only while out_valid = 1.
REQ-028 An accepted pair with acc_clr = 0 after DONE continues the accumulation, giving a dot-product mode.

Reset
REQ-029 When rst_n goes low, the block immediately enters IDLE. acc, the latched operands, i, j, out_valid, md, mr, sx and sy are all 0; in_ready = 1 from the first cycle after release.
REQ-030 Reset during RUN or DONE discards the operation; no partial result survives.

Structure
REQ-031 The shared package psmac_pkg holds:
- the FSM state enum {IDLE, RUN, DONE};
- the digit width constant (2);
- the product width constant (5).
REQ-032 One sub-module, psmac_align, SHALL sign-extend p to ACC_W and shift it by 2*(i+j) combinationally.
REQ-033 The digit multiplier is external. It connects through md, mr, sx, sy and p and is not instantiated inside this block.

Verification
REQ-034 The bench SHALL use a golden digit multiplier per REQ-016 connected to p, and SHALL cover these directed scenarios:
- Unsigned 255 x 255 with acc_clr = 1: out_valid high exactly 16 cycles after accept; acc = 65025.
- Signed -128 x 127 with acc_clr = 1: acc = -16256 (0xFFC080).
- Mixed: a = -1 signed, b = 255 unsigned: acc = -255. Then 3 x 4 unsigned with acc_clr = 0: acc = -243.
- Backpressure: out_ready held 0 for 5 cycles in DONE: acc, out_valid and in_ready = 0 all stable. in_valid pulses during RUN are not accepted.
- rst_n pulsed low at RUN step 7: acc = 0 and in_ready = 1 next cycle. A following 2 x 3 unsigned op with acc_clr = 0 gives acc = 6.
- Signed -128 x -128 with acc_clr = 0, repeated 1024 times from 0: acc = 16777216 mod 2^24 = 0, proving wrap-around.
